// File: rtl/image_mode_pkg.sv
// Purpose: shared mode codes, scheduler state encoding and default sizes for image_mode_sched.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package image_mode_pkg;

  localparam int MODE_W            = 8;
  localparam int DEFAULT_NUM_MODES = 8;
  localparam int DEFAULT_CNT_W     = 8;

  // Processing-stage codes carried on image_mode_o.
  localparam logic [MODE_W-1:0] MODE_BYPASS      = 8'd0;
  localparam logic [MODE_W-1:0] MODE_GRAY        = 8'd1;
  localparam logic [MODE_W-1:0] MODE_BLUR        = 8'd2;
  localparam logic [MODE_W-1:0] MODE_SHARPEN     = 8'd3;
  localparam logic [MODE_W-1:0] MODE_WHITE_BLACK = 8'd4;
  localparam logic [MODE_W-1:0] MODE_EDGE        = 8'd5;
  localparam logic [MODE_W-1:0] MODE_INVERT      = 8'd6;
  localparam logic [MODE_W-1:0] MODE_HIST_EQ     = 8'd7;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_AUTO    = 2'd1,
    ST_PENDING = 2'd2
  } state_e;

endpackage

// File: rtl/image_mode_sched_mode_next_pick.sv
// Purpose: pick the next auto-cycle mode: first set mask bit after cur_mode_i, wrapping.
// Latency: combinational.
// Backpressure: none.
// Ports: cur_mode_i (current code), mask_i (mode set), next_mode_o, found_o (mask non-empty).
// Only elaborated when IMAGE_MODE_SCHED_AUTO_EN is defined, the sole build that instantiates it.
`ifdef IMAGE_MODE_SCHED_AUTO_EN
module mode_next_pick
  import image_mode_pkg::*;
#(
  parameter int NUM_MODES = DEFAULT_NUM_MODES
) (
  input  logic [MODE_W-1:0]    cur_mode_i,
  input  logic [NUM_MODES-1:0] mask_i,
  output logic [MODE_W-1:0]    next_mode_o,
  output logic                 found_o
);

  int dist;
  int best;

  // Forward distance from the current mode, 1..NUM_MODES; the current mode itself
  // counts as a full wrap so a single-bit mask re-selects the same code.
  always_comb begin
    dist        = 0;
    best        = NUM_MODES + 1;
    next_mode_o = cur_mode_i;
    found_o     = 1'b0;
    for (int i = 0; i < NUM_MODES; i++) begin
      dist = i - int'(cur_mode_i);
      if (dist <= 0) dist = dist + NUM_MODES;
      if (mask_i[i] && (dist < best)) begin
        best        = dist;
        next_mode_o = MODE_W'(i);
        found_o     = 1'b1;
      end
    end
  end

endmodule
`endif

// File: rtl/image_mode_sched.sv
// Purpose: frame-synchronous scheduler for image_mode; applies host requests or auto-cycle steps at vs falling edges.
// Latency: image_mode_o/mode_change_o update on the clock that samples the vs fall; req_ready_o one clock after transfer/apply.
// Backpressure: req_ready_o low while a request is held, until the next vs fall applies it.
// Ports: clock, reset_n (async, active-low), vs_i, req_valid_i/req_mode_i/req_ready_o (host request),
//        auto_en_i/auto_mask_i/hold_frames_i (auto cycle), image_mode_o, mode_change_o, frame_cnt_o.
// Build option: IMAGE_MODE_SCHED_AUTO_EN compiles in the AUTO state; without it the auto inputs are ignored.
module image_mode_sched
  import image_mode_pkg::*;
#(
  parameter int NUM_MODES = DEFAULT_NUM_MODES,
  parameter int CNT_W     = DEFAULT_CNT_W
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 vs_i,
  input  logic                 req_valid_i,
  input  logic [MODE_W-1:0]    req_mode_i,
  output logic                 req_ready_o,
  input  logic                 auto_en_i,
  input  logic [NUM_MODES-1:0] auto_mask_i,
  input  logic [CNT_W-1:0]     hold_frames_i,
  output logic [MODE_W-1:0]    image_mode_o,
  output logic                 mode_change_o,
  output logic [CNT_W-1:0]     frame_cnt_o
);

  localparam logic [MODE_W-1:0] MODE_LIMIT = MODE_W'(NUM_MODES);

  state_e              state_q, state_d;
  logic                vs_d_q;
  logic [MODE_W-1:0]   pending_q, pending_d;
  logic [MODE_W-1:0]   image_mode_q, image_mode_d;
  logic                mode_change_q, mode_change_d;
  logic [CNT_W-1:0]    frame_cnt_q, frame_cnt_d;
  logic                req_ready_q, req_ready_d;

  logic                fall;
  logic                transfer;
  logic                auto_on;
  logic                auto_go;
  logic [MODE_W-1:0]   next_mode;

  assign fall     = vs_d_q & ~vs_i;
  assign transfer = req_valid_i & req_ready_q;

`ifdef IMAGE_MODE_SCHED_AUTO_EN
  logic             next_found;
  logic [CNT_W:0]   hold_eff;
  logic [CNT_W:0]   cnt_inc;

  mode_next_pick #(.NUM_MODES(NUM_MODES)) u_pick (
    .cur_mode_i  (image_mode_q),
    .mask_i      (auto_mask_i),
    .next_mode_o (next_mode),
    .found_o     (next_found)
  );

  // One extra bit so a saturated counter still compares correctly against hold.
  assign hold_eff = (hold_frames_i == '0) ? (CNT_W+1)'(1) : {1'b0, hold_frames_i};
  assign cnt_inc  = {1'b0, frame_cnt_q} + (CNT_W+1)'(1);
  assign auto_on  = auto_en_i;
  // A request accepted on this same fall takes priority: no auto step.
  assign auto_go  = (state_q == ST_AUTO) && auto_en_i && fall && !transfer &&
                    (cnt_inc >= hold_eff) && next_found;
`else
  logic unused_auto;
  assign unused_auto = ^{auto_en_i, auto_mask_i, hold_frames_i};
  assign next_mode   = image_mode_q;
  assign auto_on     = 1'b0;
  assign auto_go     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (transfer) state_d = ST_PENDING;
                  else if (auto_on) state_d = ST_AUTO;
      ST_AUTO:    if (transfer) state_d = ST_PENDING;
                  else if (!auto_on) state_d = ST_IDLE;
      // A request landing on a fall moved us here after that fall, so this fall is the next one.
      ST_PENDING: if (fall) state_d = auto_on ? ST_AUTO : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output / datapath logic.
  always_comb begin
    pending_d     = pending_q;
    image_mode_d  = image_mode_q;
    mode_change_d = 1'b0;
    frame_cnt_d   = frame_cnt_q;

    if (transfer) pending_d = (req_mode_i >= MODE_LIMIT) ? MODE_BYPASS : req_mode_i;

    if (state_q == ST_PENDING) begin
      if (fall) begin
        image_mode_d  = pending_q;
        mode_change_d = (pending_q != image_mode_q);
        frame_cnt_d   = '0;
      end
    end else if (fall) begin
      if (auto_go) begin
        image_mode_d  = next_mode;
        mode_change_d = (next_mode != image_mode_q);
        frame_cnt_d   = '0;
      end else if (frame_cnt_q != '1) begin
        frame_cnt_d   = frame_cnt_q + CNT_W'(1);
      end
    end

    req_ready_d = (state_d != ST_PENDING);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      vs_d_q        <= 1'b0;
      pending_q     <= MODE_BYPASS;
      image_mode_q  <= MODE_BYPASS;
      mode_change_q <= 1'b0;
      frame_cnt_q   <= '0;
      req_ready_q   <= 1'b1;
    end else begin
      vs_d_q        <= vs_i;
      pending_q     <= pending_d;
      image_mode_q  <= image_mode_d;
      mode_change_q <= mode_change_d;
      frame_cnt_q   <= frame_cnt_d;
      req_ready_q   <= req_ready_d;
    end
  end

  assign req_ready_o   = req_ready_q;
  assign image_mode_o  = image_mode_q;
  assign mode_change_o = mode_change_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_image_mode_sched.sv
// Purpose: self-checking bench for image_mode_sched (behavioural model + directed literal checks).
// Latency: n/a.
// Backpressure: n/a.
module tb_image_mode_sched;

  localparam int NM = 8;
  localparam int CW = 8;
`ifdef IMAGE_MODE_SCHED_AUTO_EN
  localparam bit AUTO_BUILT = 1'b1;
`else
  localparam bit AUTO_BUILT = 1'b0;
`endif

  logic          clock         = 1'b0;
  logic          reset_n       = 1'b0;
  logic          vs_i          = 1'b0;
  logic          req_valid_i   = 1'b0;
  logic [7:0]    req_mode_i    = 8'd0;
  logic          req_ready_o;
  logic          auto_en_i     = 1'b0;
  logic [NM-1:0] auto_mask_i   = '0;
  logic [CW-1:0] hold_frames_i = '0;
  logic [7:0]    image_mode_o;
  logic          mode_change_o;
  logic [CW-1:0] frame_cnt_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  always #5 clock = ~clock;

  image_mode_sched #(.NUM_MODES(NM), .CNT_W(CW)) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .vs_i          (vs_i),
    .req_valid_i   (req_valid_i),
    .req_mode_i    (req_mode_i),
    .req_ready_o   (req_ready_o),
    .auto_en_i     (auto_en_i),
    .auto_mask_i   (auto_mask_i),
    .hold_frames_i (hold_frames_i),
    .image_mode_o  (image_mode_o),
    .mode_change_o (mode_change_o),
    .frame_cnt_o   (frame_cnt_o)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Frame-level view: a held request (if any), the visible mode, frames since last apply,
  // and whether auto cycling was enabled as of the previous clock.
  bit m_vs_prev, m_has_req, m_auto, m_pulse;
  int m_req, m_mode, m_cnt;

  task automatic model_step();
    bit fall, accept, adv;
    int hold, nxt;
    if (!reset_n) begin
      m_vs_prev = 0; m_has_req = 0; m_auto = 0; m_pulse = 0;
      m_req = 0; m_mode = 0; m_cnt = 0;
      return;
    end
    fall    = m_vs_prev && !vs_i;
    accept  = req_valid_i && !m_has_req;
    m_pulse = 0;
    adv     = 0;
    nxt     = m_mode;
    if (m_has_req) begin
      if (fall) begin
        m_pulse   = (m_req != m_mode);
        m_mode    = m_req;
        m_cnt     = 0;
        m_has_req = 0;
      end
    end else begin
      if (fall && m_auto && auto_en_i && !accept) begin
        hold = (hold_frames_i == 0) ? 1 : int'(hold_frames_i);
        if (m_cnt + 1 >= hold)
          for (int k = 1; k <= NM; k++)
            if (!adv && auto_mask_i[(m_mode + k) % NM]) begin
              adv = 1;
              nxt = (m_mode + k) % NM;
            end
      end
      if (adv) begin
        m_pulse = (nxt != m_mode);
        m_mode  = nxt;
        m_cnt   = 0;
      end else if (fall) begin
        m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
      end
      if (accept) begin
        m_has_req = 1;
        m_req     = (req_mode_i < NM) ? int'(req_mode_i) : 0;
      end
    end
    m_auto    = AUTO_BUILT && auto_en_i;
    m_vs_prev = vs_i;
  endtask

  // Compare process: model advances on each rising edge, DUT sampled 1 time unit later.
  initial begin
    forever begin
      @(posedge clock);
      model_step();
      #1;
      if (done) break;
      chk("cyc_image_mode", int'(image_mode_o), m_mode);
      chk("cyc_mode_change", int'(mode_change_o), int'(m_pulse));
      chk("cyc_req_ready", int'(req_ready_o), int'(!m_has_req));
      chk("cyc_frame_cnt", int'(frame_cnt_o), m_cnt);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic do_fall();
    @(negedge clock); vs_i = 1'b1;
    repeat (3) @(negedge clock);
    vs_i = 1'b0;
    @(posedge clock); #2;
  endtask

  task automatic send_req(input int m);
    @(negedge clock);
    chk("ready_before_req", int'(req_ready_o), 1);
    req_valid_i = 1'b1; req_mode_i = 8'(m);
    @(posedge clock); #2;
    chk("ready_drop_after_transfer", int'(req_ready_o), 0);
    @(negedge clock); req_valid_i = 1'b0;
  endtask

  int exp_seq[4];
  int exp_seq_pulse[4];
  int exp_h0[3];
  int exp_sat_mode;

  initial begin
`ifdef IMAGE_MODE_SCHED_AUTO_EN
    exp_seq = '{2, 4, 0, 2}; exp_seq_pulse = '{1, 1, 1, 1};
    exp_h0  = '{4, 0, 2};    exp_sat_mode  = 2;
`else
    exp_seq = '{0, 0, 0, 0}; exp_seq_pulse = '{0, 0, 0, 0};
    exp_h0  = '{0, 0, 0};    exp_sat_mode  = 0;
`endif
    repeat (3) @(negedge clock);
    @(posedge clock); #2;
    chk("reset_image_mode", int'(image_mode_o), 0);
    chk("reset_mode_change", int'(mode_change_o), 0);
    chk("reset_req_ready", int'(req_ready_o), 1);
    chk("reset_frame_cnt", int'(frame_cnt_o), 0);
    @(negedge clock); reset_n = 1'b1;
    repeat (2) @(negedge clock);

    // Request 4 mid-frame, applied at the next fall.
    send_req(4);
    do_fall();
    chk("req4_mode", int'(image_mode_o), 4);
    chk("req4_pulse", int'(mode_change_o), 1);
    chk("req4_cnt", int'(frame_cnt_o), 0);
    chk("req4_ready_back", int'(req_ready_o), 1);
    @(posedge clock); #2;
    chk("req4_pulse_one_cycle", int'(mode_change_o), 0);

    // Out-of-range request maps to bypass; repeat gives no pulse but clears counter.
    send_req(9);
    do_fall();
    chk("req9_mode", int'(image_mode_o), 0);
    chk("req9_pulse", int'(mode_change_o), 1);
    do_fall(); do_fall();
    chk("idle_cnt_two", int'(frame_cnt_o), 2);
    send_req(9);
    do_fall();
    chk("req9_again_mode", int'(image_mode_o), 0);
    chk("req9_again_no_pulse", int'(mode_change_o), 0);
    chk("req9_again_cnt", int'(frame_cnt_o), 0);

    // Transfer on the same clock as a fall: held to the following fall.
    @(negedge clock); vs_i = 1'b1;
    repeat (3) @(negedge clock);
    vs_i = 1'b0; req_valid_i = 1'b1; req_mode_i = 8'd5;
    @(posedge clock); #2;
    chk("samefall_mode_kept", int'(image_mode_o), 0);
    chk("samefall_ready", int'(req_ready_o), 0);
    chk("samefall_cnt", int'(frame_cnt_o), 1);
    @(negedge clock); req_valid_i = 1'b0;
    do_fall();
    chk("samefall_applied_next", int'(image_mode_o), 5);
    chk("samefall_pulse", int'(mode_change_o), 1);

    // Auto cycle from mode 0, mask {0,2,4}, hold 2.
    send_req(0);
    do_fall();
    chk("auto_start_mode", int'(image_mode_o), 0);
    @(negedge clock); auto_en_i = 1'b1; auto_mask_i = 8'b0001_0101; hold_frames_i = 8'd2;
    for (int i = 0; i < 4; i++) begin
      do_fall();
      chk("auto_hold_first_frame_no_pulse", int'(mode_change_o), 0);
      do_fall();
      chk("auto_seq_mode", int'(image_mode_o), exp_seq[i]);
      chk("auto_seq_pulse", int'(mode_change_o), exp_seq_pulse[i]);
    end

    // hold 0 behaves as 1: step every frame.
    @(negedge clock); hold_frames_i = 8'd0;
    for (int i = 0; i < 3; i++) begin
      do_fall();
      chk("auto_hold0_mode", int'(image_mode_o), exp_h0[i]);
    end

    // Empty mask: no change, counter saturates.
    @(negedge clock); auto_mask_i = '0;
    repeat (260) do_fall();
    chk("auto_mask0_cnt_sat", int'(frame_cnt_o), 255);
    chk("auto_mask0_mode", int'(image_mode_o), exp_sat_mode);

    // Manual request while auto is running wins over the auto step.
    @(negedge clock); auto_mask_i = 8'b0001_0101; hold_frames_i = 8'd1;
    send_req(6);
    do_fall();
    chk("manual_prio_mode", int'(image_mode_o), 6);
    chk("manual_prio_pulse", int'(mode_change_o), 1);

    // Reset while a request is pending discards it.
    @(negedge clock); auto_en_i = 1'b0;
    repeat (2) @(negedge clock);
    send_req(3);
    @(negedge clock); reset_n = 1'b0;
    @(posedge clock); #2;
    chk("pend_reset_mode", int'(image_mode_o), 0);
    chk("pend_reset_ready", int'(req_ready_o), 1);
    chk("pend_reset_cnt", int'(frame_cnt_o), 0);
    chk("pend_reset_pulse", int'(mode_change_o), 0);
    @(negedge clock); reset_n = 1'b1;
    do_fall(); do_fall();
    chk("post_reset_mode", int'(image_mode_o), 0);
    chk("post_reset_cnt", int'(frame_cnt_o), 2);
    chk("post_reset_ready", int'(req_ready_o), 1);

    done = 1'b1;
    @(posedge clock); #3;
    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
